// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, minimum usable divisor and the
// receiver state encoding. UART_v1 imports the same package.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int DIV_W          = 16;
    localparam int DIV_MIN        = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for the UART receiver. The counter restarts whenever the
// FSM asks for it and flags the mid-bit and full-bit points of the period.
module uart_rx_bit_timer #(
    parameter int DIV_W = uart_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             half_tick,
    output logic             full_tick
);

    logic [DIV_W-1:0] cnt_q;

    // Count clocks within the current bit period; clear restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    // Divisors below two never reach these compares because the FSM stays idle.
    assign half_tick = (cnt_q == ((div >> 1) - DIV_W'(1)));
    assign full_tick = (cnt_q == (div - DIV_W'(1)));

endmodule

// File: rtl/uart_rx_word.sv
// UART 8N1 receiver that assembles consecutive bytes, first byte in the low
// lane, into one output word. Holds the input synchronizer, receive FSM,
// shift register and word assembly; bit timing lives in uart_rx_bit_timer.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = uart_pkg::DATA_BITS,
    parameter int BYTES_PER_WORD = uart_pkg::BYTES_PER_WORD,
    parameter int DIV_W          = uart_pkg::DIV_W,
    localparam int WORD_W        = DATA_BITS * BYTES_PER_WORD,
    localparam int BC_W          = $clog2(BYTES_PER_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_en,
    input  logic [DIV_W-1:0]  div_in,
    input  logic              ser_rx,
    output logic [WORD_W-1:0] d_out,
    output logic              rx_valid,
    output logic              rx_busy,
    output logic              frame_err,
    output logic [BC_W-1:0]   byte_cnt
);

    localparam int BI_W = $clog2(DATA_BITS);

    logic                 sync1_q, rx_s, rx_prev_q;
    rx_state_t            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [WORD_W-1:0]    dout_q, dout_d;
    logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 timer_clear, half_tick, full_tick;

    uart_rx_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .div       (div_q),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // Two-flop synchronizer plus one history flop for start-edge detection;
    // all reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= ser_rx;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
        end
    end

    // Receive FSM and word assembly; a start needs a falling edge so a held
    // break line cannot retrigger after a framing error.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        word_d      = word_q;
        dout_d      = dout_q;
        byte_cnt_d  = byte_cnt_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        timer_clear = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (div_en) begin
                    div_d      = div_in;
                    byte_cnt_d = '0;
                end
                if (!rx_s && rx_prev_q && (div_q >= DIV_W'(DIV_MIN))) begin
                    state_d = START;
                end
            end
            START: begin
                if (half_tick) begin
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick) begin
                    timer_clear = 1'b1;
                    shreg_d     = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BI_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BI_W'(1);
                    end
                end
            end
            STOP: begin
                if (full_tick) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        word_d[byte_cnt_q*DATA_BITS +: DATA_BITS] = shreg_q;
                        if (byte_cnt_q == BC_W'(BYTES_PER_WORD - 1)) begin
                            dout_d     = word_d;
                            valid_d    = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                    end else begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            timer_clear = 1'b1;
        end
    end

    // Register FSM state, datapath and output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            dout_q     <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            dout_q     <= dout_d;
            byte_cnt_q <= byte_cnt_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign d_out     = dout_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign byte_cnt  = byte_cnt_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed testbench for uart_rx_word: drives 8N1 frames on ser_rx and checks
// assembled words, error pulses and busy/byte-count behaviour.
module tb_uart_rx_word;

    logic        clk;
    logic        rst;
    logic        div_en;
    logic [15:0] div_in;
    logic        ser_rx;
    logic [31:0] d_out;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic [1:0]  byte_cnt;

    int checks;
    int errors;
    int bitLen;
    int validCnt, ferrCnt, busyCnt, bothCnt;
    int v0, f0, b0;

    uart_rx_word dut (
        .clk       (clk),
        .rst       (rst),
        .div_en    (div_en),
        .div_in    (div_in),
        .ser_rx    (ser_rx),
        .d_out     (d_out),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .byte_cnt  (byte_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count output pulses and busy cycles away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) validCnt <= validCnt + 1;
            if (frame_err) ferrCnt <= ferrCnt + 1;
            if (rx_busy) busyCnt <= busyCnt + 1;
            if (rx_valid && frame_err) bothCnt <= bothCnt + 1;
        end
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one 8N1 frame at the current bit length; stopOk=0 holds the stop bit low.
    task automatic applyStimulus(input logic [7:0] b, input logic stopOk);
        ser_rx = 1'b0;
        repeat (bitLen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (bitLen) @(negedge clk);
        end
        ser_rx = stopOk;
        repeat (bitLen) @(negedge clk);
    endtask

    // One-cycle divisor strobe.
    task automatic programDiv(input logic [15:0] d);
        div_in = d;
        div_en = 1'b1;
        @(negedge clk);
        div_en = 1'b0;
    endtask

    task automatic idle(input int n);
        ser_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Linear sequence of directed test steps.
    initial begin
        checks = 0; errors = 0;
        validCnt = 0; ferrCnt = 0; busyCnt = 0; bothCnt = 0;
        rst = 1'b1; div_en = 1'b0; div_in = '0; ser_rx = 1'b1; bitLen = 4;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_d_out", d_out, 32'h0);
        checkOutput("reset_rx_valid", {31'b0, rx_valid}, 32'h0);
        checkOutput("reset_frame_err", {31'b0, frame_err}, 32'h0);
        checkOutput("reset_byte_cnt", {30'b0, byte_cnt}, 32'h0);
        checkOutput("reset_rx_busy", {31'b0, rx_busy}, 32'h0);

        // Baud not set: a low line must not start a frame.
        b0 = busyCnt; v0 = validCnt; f0 = ferrCnt;
        ser_rx = 1'b0;
        repeat (6) @(negedge clk);
        idle(6);
        checkOutput("nodiv_busy", busyCnt - b0, 0);
        checkOutput("nodiv_valid", validCnt - v0, 0);
        checkOutput("nodiv_ferr", ferrCnt - f0, 0);

        // Four back-to-back bytes at divisor 4.
        bitLen = 4;
        programDiv(16'd4);
        idle(4);
        v0 = validCnt; f0 = ferrCnt;
        applyStimulus(8'h08, 1'b1);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h81, 1'b1);
        idle(10);
        checkOutput("word1_valid_count", validCnt - v0, 1);
        checkOutput("word1_d_out", d_out, 32'h81020408);
        checkOutput("word1_ferr", ferrCnt - f0, 0);
        checkOutput("word1_byte_cnt", {30'b0, byte_cnt}, 32'h0);

        // Bad stop bit on the second byte drops the partial word.
        v0 = validCnt; f0 = ferrCnt;
        applyStimulus(8'h11, 1'b1);
        idle(2);
        checkOutput("ferr_pre_byte_cnt", {30'b0, byte_cnt}, 32'h1);
        applyStimulus(8'h22, 1'b0);
        idle(8);
        checkOutput("ferr_count", ferrCnt - f0, 1);
        checkOutput("ferr_byte_cnt", {30'b0, byte_cnt}, 32'h0);
        checkOutput("ferr_no_valid", validCnt - v0, 0);
        applyStimulus(8'hEF, 1'b1);
        applyStimulus(8'hBE, 1'b1);
        applyStimulus(8'hAD, 1'b1);
        applyStimulus(8'hDE, 1'b1);
        idle(10);
        checkOutput("word2_d_out", d_out, 32'hDEADBEEF);
        checkOutput("word2_valid_count", validCnt - v0, 1);
        checkOutput("word2_ferr_total", ferrCnt - f0, 1);

        // Divisor 8: one good byte, then a one-cycle glitch is rejected.
        bitLen = 8;
        programDiv(16'd8);
        idle(4);
        applyStimulus(8'h5A, 1'b1);
        idle(6);
        checkOutput("glitch_pre_byte_cnt", {30'b0, byte_cnt}, 32'h1);
        v0 = validCnt; f0 = ferrCnt; b0 = busyCnt;
        ser_rx = 1'b0;
        @(negedge clk);
        idle(20);
        checkOutput("glitch_busy_seen", {31'b0, (busyCnt - b0) != 0}, 32'h1);
        checkOutput("glitch_rx_busy", {31'b0, rx_busy}, 32'h0);
        checkOutput("glitch_byte_cnt", {30'b0, byte_cnt}, 32'h1);
        checkOutput("glitch_valid", validCnt - v0, 0);
        checkOutput("glitch_ferr", ferrCnt - f0, 0);

        // Reset during DATA of the third byte.
        bitLen = 4;
        programDiv(16'd4);
        idle(4);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("rst_mid_busy", {31'b0, rx_busy}, 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_d_out", d_out, 32'h0);
        checkOutput("rst_mid_byte_cnt", {30'b0, byte_cnt}, 32'h0);
        checkOutput("rst_mid_busy_clr", {31'b0, rx_busy}, 32'h0);
        rst = 1'b0;
        idle(4);
        programDiv(16'd4);
        idle(4);
        v0 = validCnt;
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h23, 1'b1);
        applyStimulus(8'h45, 1'b1);
        applyStimulus(8'h67, 1'b1);
        idle(10);
        checkOutput("post_rst_d_out", d_out, 32'h67452301);
        checkOutput("post_rst_valid", validCnt - v0, 1);

        // Divisor strobe mid-frame is ignored; strobe in idle takes effect.
        v0 = validCnt; f0 = ferrCnt;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                repeat (15) @(negedge clk);
                div_in = 16'd6;
                div_en = 1'b1;
                @(negedge clk);
                div_en = 1'b0;
            end
        join
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'h96, 1'b1);
        idle(10);
        checkOutput("divignore_d_out", d_out, 32'h965A3CA5);
        checkOutput("divignore_valid", validCnt - v0, 1);
        checkOutput("divignore_ferr", ferrCnt - f0, 0);
        bitLen = 6;
        programDiv(16'd6);
        idle(4);
        v0 = validCnt;
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h40, 1'b1);
        idle(12);
        checkOutput("div6_d_out", d_out, 32'h40302010);
        checkOutput("div6_valid", validCnt - v0, 1);
        checkOutput("never_both_pulses", bothCnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
UART receiver that is the counterpart of the team's UART_v1 transmitter. It recovers 8N1 frames (1 start, 8 data bits LSB first, 1 stop, line idle high) from ser_rx and assembles four consecutive bytes into one 32-bit word. It uses the same divisor-programming interface as the transmitter (div_en/div_in). It sits between the board RX pin and the core-side consumer of d_out.

Parameters:
DATA_BITS, 8, data bits per frame
BYTES_PER_WORD, 4, frames assembled per output word
DIV_W, 16, width of divisor register

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
div_en  in  1  one-cycle strobe that loads div_in into the divisor register
div_in  in  DIV_W  clocks per bit period
ser_rx  in  1  asynchronous serial input, idle high
d_out  out  32  last fully received word
rx_valid  out  1  one-cycle pulse when d_out updates
rx_busy  out  1  high while a frame is in progress (not IDLE)
frame_err  out  1  one-cycle pulse on bad stop bit
byte_cnt  out  2  bytes of the current word already received

Behaviour:
Reset (asynchronous, active-high): all outputs and registers are cleared, with these values:
- div_reg=0, state=IDLE, d_out=0, rx_valid=0, frame_err=0, byte_cnt=0, rx_busy=0.
- Synchronizer flops reset to 1.
- Reset mid-frame aborts the frame and discards any partial word.

Input synchronization:
- ser_rx passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
- This adds 2 cycles of latency.

Divisor:
- div_en loads div_reg <= div_in only while state==IDLE; a strobe in any other state is ignored.
- div_reg < 2 means "baud not set": the block stays in IDLE, ignores the line and produces no outputs.
- A successful div_en also clears byte_cnt, discarding any partial word.

Bit timer:
- Counter cnt (DIV_W bits) is reset on every state entry.
- Mid-bit point is floor(div_reg/2)-1; full-bit point is div_reg-1.

FSM states and transitions:
- IDLE: rx_s==0 and div_reg>=2 -> START, cnt=0.
- START: at cnt==floor(div_reg/2)-1, sample rx_s.
  - rx_s==1: false start, return to IDLE with no outputs.
  - rx_s==0: -> DATA, cnt=0, bit_idx=0.
- DATA: at cnt==div_reg-1, shift rx_s into shreg MSB (LSB-first framing) and restart cnt.
  - After the 8th sample -> STOP.
- STOP: at cnt==div_reg-1, sample rx_s.
  - rx_s==1: byte is good. Store it at word_buf[8*byte_cnt +: 8] and increment byte_cnt.
  - If byte_cnt was 3: d_out <= completed word_buf (including this byte), rx_valid=1 for one cycle, byte_cnt wraps to 0.
  - rx_s==0: frame_err=1 for one cycle, byte discarded, byte_cnt <= 0 (partial word dropped).
  - Either outcome -> IDLE.
- Sampling is therefore mid-bit for data and stop bits.

Timing and hold rules:
- rx_valid and frame_err assert in the cycle after the stop sample.
- rx_valid and frame_err are never asserted together.
- d_out holds its value until the next complete word; there is no backpressure, and the consumer must take d_out on rx_valid.
- A new start bit is accepted in the cycle after returning to IDLE, so back-to-back frames are supported.
- A line held low (break) causes frame_err once, then the block waits in IDLE until the line goes high.
  - IDLE requires rx_s to have been 1 for at least one cycle after STOP before a new start is detected; edge-qualified on previous rx_s.

Decomposition:
Shared package uart_pkg, used by UART_v1 too:
- typedef enum rx_state_t {IDLE, START, DATA, STOP}
- constants DATA_BITS, BYTES_PER_WORD, DIV_MIN=2

Sub-module uart_rx_bit_timer:
- Ports: clk, rst, clear, div, half_tick, full_tick.
- Holds the counter and both tick compares.
- Top module holds the synchronizer, FSM, shift register and word assembly.

Test Plan:
1. Reset, then drive ser_rx low for 6 cycles with no div_en -> rx_busy stays 0; no rx_valid or frame_err.
2. div_in=4 with div_en pulse; send bytes 0x08,0x04,0x02,0x81 back-to-back, 40 clk per frame -> exactly one rx_valid, d_out=0x81020408, frame_err=0 throughout.
3. div=4; hold the stop bit low on the 2nd byte -> frame_err pulses once, byte_cnt=0, no rx_valid; the following 4 good bytes 0xDEADBEEF (EF,BE,AD,DE) -> d_out=0xDEADBEEF.
4. div=8; 1-cycle low glitch on an idle line -> START entered, mid-bit sample high, return to IDLE; no outputs, byte_cnt unchanged.
5. div=4; assert rst during DATA of the 3rd byte, then release and reprogram div -> all outputs 0; the next full 4-byte word is received correctly.
6. div=4; div_en with div_in=6 pulsed mid-frame -> ignored, current frame decoded at div 4. A pulse in IDLE applies div 6 to the next word.
